ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage of the pipelined RV32I core. Consumes the ID/EX register outputs, resolves RAW
//  hazards by forwarding from MEM and WB, runs the ALU, resolves branches/jumps, and drives the PC
//  redirect and flush. Owns the EX/MEM pipeline register that feeds the memory stage.
// PARAMETERS
//  WIDTH         32  datapath width (`WIDTH)
//  RF_ADD_SIZE    5  register-file address width (`RF_ADD_SIZE)
// PORTS
//  i_clk            in   1      clock
//  i_rstn           in   1      reset; asynchronous, active-low
//  i_ie_branch      in   1      conditional-branch instruction
//  i_ie_jump        in   1      JAL/JALR
//  i_ie_bu_jb_ctrl  in   1      jump base: 0=PC (JAL/branch), 1=rs1 (JALR)
//  i_ie_funct3      in   3      branch condition select
//  i_ie_alu_op_src_ctrl in 1    ALU B operand: 0=rs2 (forwarded), 1=immediate
//  i_ie_alu_ctrl    in   4      ALU op (see BEHAVIOUR)
//  i_ie_rf_we_ctrl  in   1      register write enable
//  i_ie_rf_wb_src_ctrl in 3     writeback source select, passed through
//  i_ie_mem_we      in   1      data memory write enable
//  i_ie_rf_src_0/1  in   WIDTH  rs1/rs2 register-file data
//  i_ie_sx_data     in   WIDTH  sign-extended immediate
//  i_ie_pc, i_ie_pc_plus4 in WIDTH  instruction PC, PC+4
//  i_ie_src_0/1     in   RF_ADD_SIZE  rs1/rs2 addresses
//  i_ie_dst         in   RF_ADD_SIZE  rd address
//  i_mem_fwd_data   in   WIDTH  MEM-stage result; i_mem_dst (RF_ADD_SIZE), i_mem_we (1)
//  i_wb_fwd_data    in   WIDTH  WB-stage result;  i_wb_dst (RF_ADD_SIZE),  i_wb_we (1)
//  i_stall          in   1      hold EX/MEM register
//  o_pc_redirect    out  1      combinational: taken branch or jump
//  o_pc_target      out  WIDTH  combinational: redirect target
//  o_flush          out  1      combinational = o_pc_redirect; drives IF/ID and ID/EX flush
//  o_im_alu_result  out  WIDTH  registered ALU result
//  o_im_store_data  out  WIDTH  registered forwarded rs2 value
//  o_im_pc_plus4    out  WIDTH  registered PC+4
//  o_im_dst         out  RF_ADD_SIZE  registered rd
//  o_im_rf_we, o_im_mem_we  out 1     registered enables
//  o_im_rf_wb_src_ctrl out 3    registered writeback select
// BEHAVIOUR
//  - Forwarding, per operand: if i_mem_we && i_mem_dst!=0 && i_mem_dst==src, use MEM data; else if
//    i_wb_we && i_wb_dst!=0 && i_wb_dst==src, use WB data; else RF data. MEM has priority over WB.
//  - ALU ops: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA,
//    1000 SLT, 1001 SLTU, 1010 pass B (LUI); others produce 0. Shift amount = B[4:0];
//    SLT/SLTU produce 0/1. All arithmetic is mod 2^WIDTH; no overflow flag.
//  - Branch compare on forwarded rs1/rs2 by funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU;
//    010/011 are never taken.
//  - o_pc_redirect = i_ie_jump | (i_ie_branch & cond).
//  - o_pc_target = (bu_jb_ctrl ? rs1_fwd : i_ie_pc) + i_ie_sx_data; bit 0 cleared when bu_jb_ctrl=1.
//  - EX/MEM register, latency 1: on posedge, if !i_stall, load ALU result, store data, pc_plus4, dst,
//    rf_we, mem_we, wb_src. If i_stall, hold all values.
//  - i_stall has priority over redirect: while stalled, o_pc_redirect and o_flush are forced to 0.
//  - The redirecting instruction itself still commits (JAL/JALR rd write via pc_plus4).
//  - Reset (async, any time, including mid-stall): every o_im_* output clears to 0, which is a NOP
//    (no write, no store). Combinational outputs follow their inputs.
// TESTING
//  ADD x3,x1,x2 with rf 5,7, no forward -> next cycle o_im_alu_result=12, o_im_dst=3, o_im_rf_we=1
//  rs1=x4, MEM dst=4 data=0x10, WB dst=4 data=0x20 -> MEM value used; dst=0 with we=1 -> RF value used
//  BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> redirect=1, target=0x120; BLTU -> redirect=0
//  JALR rs1=0x1003, imm=4, pc_plus4=0x84 -> target=0x1006, o_im_pc_plus4=0x84, flush=1 for one cycle
//  SRA A=0x80000000, B=4 -> 0xF8000000; SRL -> 0x08000000; SLTU 1<0xFFFFFFFF -> 1
//  Assert i_stall 2 cycles -> o_im_* held, no redirect; assert i_rstn=0 mid-stall -> all o_im_* 0

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage of the pipelined RV32I core: operand forwarding, ALU, branch/jump resolution,
// PC redirect/flush, and the EX/MEM pipeline register.

module ex_fwd #(
    parameter int WIDTH       = 32,
    parameter int RF_ADD_SIZE = 5
) (
    input  logic [RF_ADD_SIZE-1:0] i_src,
    input  logic [WIDTH-1:0]       i_rf_data,
    input  logic [WIDTH-1:0]       i_mem_data,
    input  logic [RF_ADD_SIZE-1:0] i_mem_dst,
    input  logic                   i_mem_we,
    input  logic [WIDTH-1:0]       i_wb_data,
    input  logic [RF_ADD_SIZE-1:0] i_wb_dst,
    input  logic                   i_wb_we,
    output logic [WIDTH-1:0]       o_data
);
    logic w_mem_hit, w_wb_hit;

    // x0 is never a forwarding source; the younger MEM result shadows WB
    assign w_mem_hit = i_mem_we && (i_mem_dst != '0) && (i_mem_dst == i_src);
    assign w_wb_hit  = i_wb_we  && (i_wb_dst  != '0) && (i_wb_dst  == i_src);
    assign o_data    = w_mem_hit ? i_mem_data : (w_wb_hit ? i_wb_data : i_rf_data);
endmodule

module ex_stage #(
    parameter int WIDTH       = 32,
    parameter int RF_ADD_SIZE = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_ie_branch,
    input  logic                   i_ie_jump,
    input  logic                   i_ie_bu_jb_ctrl,
    input  logic [2:0]             i_ie_funct3,
    input  logic                   i_ie_alu_op_src_ctrl,
    input  logic [3:0]             i_ie_alu_ctrl,
    input  logic                   i_ie_rf_we_ctrl,
    input  logic [2:0]             i_ie_rf_wb_src_ctrl,
    input  logic                   i_ie_mem_we,
    input  logic [WIDTH-1:0]       i_ie_rf_src_0,
    input  logic [WIDTH-1:0]       i_ie_rf_src_1,
    input  logic [WIDTH-1:0]       i_ie_sx_data,
    input  logic [WIDTH-1:0]       i_ie_pc,
    input  logic [WIDTH-1:0]       i_ie_pc_plus4,
    input  logic [RF_ADD_SIZE-1:0] i_ie_src_0,
    input  logic [RF_ADD_SIZE-1:0] i_ie_src_1,
    input  logic [RF_ADD_SIZE-1:0] i_ie_dst,
    input  logic [WIDTH-1:0]       i_mem_fwd_data,
    input  logic [RF_ADD_SIZE-1:0] i_mem_dst,
    input  logic                   i_mem_we,
    input  logic [WIDTH-1:0]       i_wb_fwd_data,
    input  logic [RF_ADD_SIZE-1:0] i_wb_dst,
    input  logic                   i_wb_we,
    input  logic                   i_stall,
    output logic                   o_pc_redirect,
    output logic [WIDTH-1:0]       o_pc_target,
    output logic                   o_flush,
    output logic [WIDTH-1:0]       o_im_alu_result,
    output logic [WIDTH-1:0]       o_im_store_data,
    output logic [WIDTH-1:0]       o_im_pc_plus4,
    output logic [RF_ADD_SIZE-1:0] o_im_dst,
    output logic                   o_im_rf_we,
    output logic                   o_im_mem_we,
    output logic [2:0]             o_im_rf_wb_src_ctrl
);
    localparam int NUM_OPS = 2;

    typedef struct packed {
        logic [WIDTH-1:0]       alu_result;
        logic [WIDTH-1:0]       store_data;
        logic [WIDTH-1:0]       pc_plus4;
        logic [RF_ADD_SIZE-1:0] dst;
        logic                   rf_we;
        logic                   mem_we;
        logic [2:0]             wb_src;
    } exmem_t;

    logic [NUM_OPS-1:0][RF_ADD_SIZE-1:0] w_src;
    logic [NUM_OPS-1:0][WIDTH-1:0]       w_rf;
    logic [NUM_OPS-1:0][WIDTH-1:0]       w_fwd;
    logic [WIDTH-1:0]                    w_a, w_b, w_alu_result;
    logic [WIDTH-1:0]                    w_base, w_sum;
    logic [4:0]                          w_shamt;
    logic                                w_cond;
    exmem_t                              w_exmem_d, r_exmem;

    assign w_src = {i_ie_src_1, i_ie_src_0};
    assign w_rf  = {i_ie_rf_src_1, i_ie_rf_src_0};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        ex_fwd #(.WIDTH(WIDTH), .RF_ADD_SIZE(RF_ADD_SIZE)) u_fwd (
            .i_src      (w_src[g]),
            .i_rf_data  (w_rf[g]),
            .i_mem_data (i_mem_fwd_data),
            .i_mem_dst  (i_mem_dst),
            .i_mem_we   (i_mem_we),
            .i_wb_data  (i_wb_fwd_data),
            .i_wb_dst   (i_wb_dst),
            .i_wb_we    (i_wb_we),
            .o_data     (w_fwd[g])
        );
    end

    assign w_a     = w_fwd[0];
    assign w_b     = i_ie_alu_op_src_ctrl ? i_ie_sx_data : w_fwd[1];
    assign w_shamt = w_b[4:0];

    always_comb begin
        w_alu_result = '0;
        case (i_ie_alu_ctrl)
            4'b0000: w_alu_result = w_a + w_b;
            4'b0001: w_alu_result = w_a - w_b;
            4'b0010: w_alu_result = w_a & w_b;
            4'b0011: w_alu_result = w_a | w_b;
            4'b0100: w_alu_result = w_a ^ w_b;
            4'b0101: w_alu_result = w_a << w_shamt;
            4'b0110: w_alu_result = w_a >> w_shamt;
            4'b0111: w_alu_result = $unsigned($signed(w_a) >>> w_shamt);
            4'b1000: w_alu_result = {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
            4'b1001: w_alu_result = {{(WIDTH-1){1'b0}}, w_a < w_b};
            4'b1010: w_alu_result = w_b;
            default: w_alu_result = '0;
        endcase
    end

    // Branches always compare rs1 against forwarded rs2, never the immediate
    always_comb begin
        w_cond = 1'b0;
        case (i_ie_funct3)
            3'b000:  w_cond = (w_fwd[0] == w_fwd[1]);
            3'b001:  w_cond = (w_fwd[0] != w_fwd[1]);
            3'b100:  w_cond = ($signed(w_fwd[0]) <  $signed(w_fwd[1]));
            3'b101:  w_cond = ($signed(w_fwd[0]) >= $signed(w_fwd[1]));
            3'b110:  w_cond = (w_fwd[0] <  w_fwd[1]);
            3'b111:  w_cond = (w_fwd[0] >= w_fwd[1]);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_base        = i_ie_bu_jb_ctrl ? w_fwd[0] : i_ie_pc;
    assign w_sum         = w_base + i_ie_sx_data;
    assign o_pc_target   = {w_sum[WIDTH-1:1], w_sum[0] & ~i_ie_bu_jb_ctrl};
    // A stalled instruction is not yet resolved, so it must not steer fetch
    assign o_pc_redirect = ~i_stall & (i_ie_jump | (i_ie_branch & w_cond));
    assign o_flush       = o_pc_redirect;

    always_comb begin
        w_exmem_d            = '0;
        w_exmem_d.alu_result = w_alu_result;
        w_exmem_d.store_data = w_fwd[1];
        w_exmem_d.pc_plus4   = i_ie_pc_plus4;
        w_exmem_d.dst        = i_ie_dst;
        w_exmem_d.rf_we      = i_ie_rf_we_ctrl;
        w_exmem_d.mem_we     = i_ie_mem_we;
        w_exmem_d.wb_src     = i_ie_rf_wb_src_ctrl;
    end

    // All-zero register contents are a NOP for the memory stage
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)       r_exmem <= '0;
        else if (!i_stall) r_exmem <= w_exmem_d;
    end

    assign o_im_alu_result     = r_exmem.alu_result;
    assign o_im_store_data     = r_exmem.store_data;
    assign o_im_pc_plus4       = r_exmem.pc_plus4;
    assign o_im_dst            = r_exmem.dst;
    assign o_im_rf_we          = r_exmem.rf_we;
    assign o_im_mem_we         = r_exmem.mem_we;
    assign o_im_rf_wb_src_ctrl = r_exmem.wb_src;
endmodule

// File: tb/tb_ex_stage.sv
// Directed plus randomized bench for ex_stage, checked against an arithmetic reference model.

module tb_ex_stage;
    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_ie_branch, i_ie_jump, i_ie_bu_jb_ctrl, i_ie_alu_op_src_ctrl;
    logic [2:0]  i_ie_funct3, i_ie_rf_wb_src_ctrl;
    logic [3:0]  i_ie_alu_ctrl;
    logic        i_ie_rf_we_ctrl, i_ie_mem_we;
    logic [31:0] i_ie_rf_src_0, i_ie_rf_src_1, i_ie_sx_data, i_ie_pc, i_ie_pc_plus4;
    logic [4:0]  i_ie_src_0, i_ie_src_1, i_ie_dst;
    logic [31:0] i_mem_fwd_data, i_wb_fwd_data;
    logic [4:0]  i_mem_dst, i_wb_dst;
    logic        i_mem_we, i_wb_we, i_stall;
    logic        o_pc_redirect, o_flush;
    logic [31:0] o_pc_target, o_im_alu_result, o_im_store_data, o_im_pc_plus4;
    logic [4:0]  o_im_dst;
    logic        o_im_rf_we, o_im_mem_we;
    logic [2:0]  o_im_rf_wb_src_ctrl;

    int n_vec = 0;
    int n_err = 0;

    // Model of the EX/MEM register contents
    logic [31:0] e_alu, e_sd, e_pc4;
    logic [4:0]  e_dst;
    logic        e_rfwe, e_memwe;
    logic [2:0]  e_wbsrc;

    ex_stage #(.WIDTH(32), .RF_ADD_SIZE(5)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_ie_branch(i_ie_branch), .i_ie_jump(i_ie_jump), .i_ie_bu_jb_ctrl(i_ie_bu_jb_ctrl),
        .i_ie_funct3(i_ie_funct3), .i_ie_alu_op_src_ctrl(i_ie_alu_op_src_ctrl),
        .i_ie_alu_ctrl(i_ie_alu_ctrl), .i_ie_rf_we_ctrl(i_ie_rf_we_ctrl),
        .i_ie_rf_wb_src_ctrl(i_ie_rf_wb_src_ctrl), .i_ie_mem_we(i_ie_mem_we),
        .i_ie_rf_src_0(i_ie_rf_src_0), .i_ie_rf_src_1(i_ie_rf_src_1),
        .i_ie_sx_data(i_ie_sx_data), .i_ie_pc(i_ie_pc), .i_ie_pc_plus4(i_ie_pc_plus4),
        .i_ie_src_0(i_ie_src_0), .i_ie_src_1(i_ie_src_1), .i_ie_dst(i_ie_dst),
        .i_mem_fwd_data(i_mem_fwd_data), .i_mem_dst(i_mem_dst), .i_mem_we(i_mem_we),
        .i_wb_fwd_data(i_wb_fwd_data), .i_wb_dst(i_wb_dst), .i_wb_we(i_wb_we),
        .i_stall(i_stall),
        .o_pc_redirect(o_pc_redirect), .o_pc_target(o_pc_target), .o_flush(o_flush),
        .o_im_alu_result(o_im_alu_result), .o_im_store_data(o_im_store_data),
        .o_im_pc_plus4(o_im_pc_plus4), .o_im_dst(o_im_dst), .o_im_rf_we(o_im_rf_we),
        .o_im_mem_we(o_im_mem_we), .o_im_rf_wb_src_ctrl(o_im_rf_wb_src_ctrl)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fwd(input logic [4:0] s, input logic [31:0] rf);
        if (i_mem_we && i_mem_dst != 0 && i_mem_dst == s) return i_mem_fwd_data;
        if (i_wb_we && i_wb_dst != 0 && i_wb_dst == s)    return i_wb_fwd_data;
        return rf;
    endfunction

    function automatic longint sgn(input logic [31:0] v);
        return v[31] ? longint'(v) - 64'sd4294967296 : longint'(v);
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p, sa;
        int     sh;
        sh = int'(b % 32);
        p  = 64'sd1 << sh;
        sa = sgn(a);
        case (op)
            4'd0:    return 32'(longint'(a) + longint'(b));
            4'd1:    return 32'(longint'(a) - longint'(b));
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return 32'(longint'(a) * p);
            4'd6:    return 32'(longint'(a) / p);
            4'd7:    return 32'((sa >= 0) ? sa / p : -((-sa + p - 1) / p));
            4'd8:    return (sgn(a) < sgn(b)) ? 32'd1 : 32'd0;
            4'd9:    return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return sgn(a) <  sgn(b);
            3'd5:    return sgn(a) >= sgn(b);
            3'd6:    return longint'(a) <  longint'(b);
            3'd7:    return longint'(a) >= longint'(b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic clr_inputs();
        i_ie_branch = 0; i_ie_jump = 0; i_ie_bu_jb_ctrl = 0; i_ie_funct3 = 0;
        i_ie_alu_op_src_ctrl = 0; i_ie_alu_ctrl = 0; i_ie_rf_we_ctrl = 0;
        i_ie_rf_wb_src_ctrl = 0; i_ie_mem_we = 0;
        i_ie_rf_src_0 = 0; i_ie_rf_src_1 = 0; i_ie_sx_data = 0; i_ie_pc = 0; i_ie_pc_plus4 = 0;
        i_ie_src_0 = 0; i_ie_src_1 = 0; i_ie_dst = 0;
        i_mem_fwd_data = 0; i_mem_dst = 0; i_mem_we = 0;
        i_wb_fwd_data = 0; i_wb_dst = 0; i_wb_we = 0; i_stall = 0;
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_alu"},   o_im_alu_result, e_alu);
        chk({tag, "_sd"},    o_im_store_data, e_sd);
        chk({tag, "_pc4"},   o_im_pc_plus4, e_pc4);
        chk({tag, "_dst"},   32'(o_im_dst), 32'(e_dst));
        chk({tag, "_rfwe"},  32'(o_im_rf_we), 32'(e_rfwe));
        chk({tag, "_memwe"}, 32'(o_im_mem_we), 32'(e_memwe));
        chk({tag, "_wbsrc"}, 32'(o_im_rf_wb_src_ctrl), 32'(e_wbsrc));
    endtask

    task automatic model_reset();
        e_alu = 0; e_sd = 0; e_pc4 = 0; e_dst = 0; e_rfwe = 0; e_memwe = 0; e_wbsrc = 0;
    endtask

    // Inputs already applied: check combinational outputs, clock once, check the register
    task automatic step(input string tag);
        logic [31:0] a, rs2, b, tgt;
        logic        redir;
        a     = m_fwd(i_ie_src_0, i_ie_rf_src_0);
        rs2   = m_fwd(i_ie_src_1, i_ie_rf_src_1);
        b     = i_ie_alu_op_src_ctrl ? i_ie_sx_data : rs2;
        redir = !i_stall && (i_ie_jump || (i_ie_branch && m_cond(i_ie_funct3, a, rs2)));
        tgt   = 32'(longint'(i_ie_bu_jb_ctrl ? a : i_ie_pc) + longint'(i_ie_sx_data));
        if (i_ie_bu_jb_ctrl) tgt = tgt & ~32'd1;
        #1;
        chk({tag, "_redir"},  32'(o_pc_redirect), 32'(redir));
        chk({tag, "_flush"},  32'(o_flush), 32'(redir));
        chk({tag, "_target"}, o_pc_target, tgt);
        if (!i_stall) begin
            e_alu = m_alu(i_ie_alu_ctrl, a, b); e_sd = rs2; e_pc4 = i_ie_pc_plus4;
            e_dst = i_ie_dst; e_rfwe = i_ie_rf_we_ctrl; e_memwe = i_ie_mem_we;
            e_wbsrc = i_ie_rf_wb_src_ctrl;
        end
        @(posedge i_clk); #1;
        chk_regs(tag);
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clr_inputs();
        model_reset();
        i_rstn = 0;
        #12;
        chk_regs("reset");
        @(negedge i_clk) i_rstn = 1;
        @(posedge i_clk); #1;

        // ADD x3,x1,x2
        i_ie_src_0 = 1; i_ie_src_1 = 2; i_ie_rf_src_0 = 5; i_ie_rf_src_1 = 7;
        i_ie_dst = 3; i_ie_rf_we_ctrl = 1; i_ie_rf_wb_src_ctrl = 3'd1; i_ie_pc_plus4 = 32'h44;
        step("add");
        chk("add_12", o_im_alu_result, 32'd12);
        chk("add_rd", 32'(o_im_dst), 32'd3);

        // MEM beats WB on the same rd
        clr_inputs();
        i_ie_alu_op_src_ctrl = 1; i_ie_src_0 = 4; i_ie_rf_src_0 = 32'h99; i_ie_rf_we_ctrl = 1;
        i_mem_we = 1; i_mem_dst = 4; i_mem_fwd_data = 32'h10;
        i_wb_we = 1;  i_wb_dst = 4;  i_wb_fwd_data = 32'h20;
        step("fwd_mem");
        chk("fwd_mem_val", o_im_alu_result, 32'h10);
        i_mem_we = 0;
        step("fwd_wb");
        chk("fwd_wb_val", o_im_alu_result, 32'h20);
        i_ie_src_0 = 0; i_mem_we = 1; i_mem_dst = 0; i_wb_dst = 0;
        step("fwd_x0");
        chk("fwd_x0_val", o_im_alu_result, 32'h99);

        // BLT / BLTU
        clr_inputs();
        i_ie_branch = 1; i_ie_funct3 = 3'b100; i_ie_src_0 = 1; i_ie_src_1 = 2;
        i_ie_rf_src_0 = 32'hFFFF_FFFF; i_ie_rf_src_1 = 1; i_ie_pc = 32'h100; i_ie_sx_data = 32'h20;
        #1;
        chk("blt_redir", 32'(o_pc_redirect), 32'd1);
        chk("blt_target", o_pc_target, 32'h120);
        step("blt");
        i_ie_funct3 = 3'b110;
        #1;
        chk("bltu_redir", 32'(o_pc_redirect), 32'd0);
        step("bltu");

        // JALR
        clr_inputs();
        i_ie_jump = 1; i_ie_bu_jb_ctrl = 1; i_ie_src_0 = 5; i_ie_rf_src_0 = 32'h1003;
        i_ie_sx_data = 4; i_ie_pc = 32'h80; i_ie_pc_plus4 = 32'h84; i_ie_dst = 1;
        i_ie_rf_we_ctrl = 1; i_ie_rf_wb_src_ctrl = 3'd2;
        #1;
        chk("jalr_target", o_pc_target, 32'h1006);
        chk("jalr_flush", 32'(o_flush), 32'd1);
        step("jalr");
        chk("jalr_pc4", o_im_pc_plus4, 32'h84);
        clr_inputs();
        step("post_jalr");

        // Shifts and SLTU with immediate B
        i_ie_alu_op_src_ctrl = 1; i_ie_rf_src_0 = 32'h8000_0000; i_ie_sx_data = 4;
        i_ie_alu_ctrl = 4'b0111; step("sra");
        chk("sra_val", o_im_alu_result, 32'hF800_0000);
        i_ie_alu_ctrl = 4'b0110; step("srl");
        chk("srl_val", o_im_alu_result, 32'h0800_0000);
        i_ie_rf_src_0 = 1; i_ie_sx_data = 32'hFFFF_FFFF; i_ie_alu_ctrl = 4'b1001; step("sltu");
        chk("sltu_val", o_im_alu_result, 32'd1);

        // Two stalled cycles carrying a jump: held register, no redirect
        clr_inputs();
        i_ie_alu_ctrl = 4'b0000; i_ie_rf_src_0 = 32'h55; i_ie_rf_src_1 = 32'h11;
        i_ie_dst = 7; i_ie_rf_we_ctrl = 1; i_ie_mem_we = 1; i_ie_pc_plus4 = 32'h204;
        step("pre_stall");
        i_stall = 1; i_ie_jump = 1; i_ie_rf_src_0 = 32'h1234; i_ie_dst = 9;
        step("stall1");
        step("stall2");
        chk("stall_held", o_im_alu_result, 32'h66);

        // Reset mid-stall, away from a clock edge
        #2 i_rstn = 0;
        #1;
        model_reset();
        chk_regs("rst_stall");
        @(negedge i_clk) i_rstn = 1;
        i_stall = 0;
        clr_inputs();
        step("post_rst");

        for (int k = 0; k < 200; k++) begin
            i_ie_branch = 1'($urandom); i_ie_jump = ($urandom_range(0, 5) == 0);
            i_ie_bu_jb_ctrl = 1'($urandom); i_ie_funct3 = 3'($urandom);
            i_ie_alu_op_src_ctrl = 1'($urandom); i_ie_alu_ctrl = 4'($urandom);
            i_ie_rf_we_ctrl = 1'($urandom); i_ie_rf_wb_src_ctrl = 3'($urandom);
            i_ie_mem_we = 1'($urandom);
            i_ie_rf_src_0 = rv(); i_ie_rf_src_1 = rv(); i_ie_sx_data = rv();
            i_ie_pc = $urandom; i_ie_pc_plus4 = $urandom;
            i_ie_src_0 = 5'($urandom_range(0, 3)); i_ie_src_1 = 5'($urandom_range(0, 3));
            i_ie_dst = 5'($urandom);
            i_mem_fwd_data = rv(); i_mem_dst = 5'($urandom_range(0, 3)); i_mem_we = 1'($urandom);
            i_wb_fwd_data = rv();  i_wb_dst = 5'($urandom_range(0, 3));  i_wb_we = 1'($urandom);
            i_stall = ($urandom_range(0, 4) == 0);
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
